// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus bus types plus the states and limits used by the cbus arbiter.
package cbus_arbiter_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;
  typedef logic [7:0]  mlen_t;

  typedef enum logic [2:0] {
    MSIZE1,
    MSIZE2,
    MSIZE4,
    MSIZE8
  } msize_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED,
    AXI_BURST_INCR,
    AXI_BURST_WRAP
  } axi_burst_type_t;

  // Burst length is encoded as beats - 1.
  localparam mlen_t MLEN1  = 8'd0;
  localparam mlen_t MLEN2  = 8'd1;
  localparam mlen_t MLEN4  = 8'd3;
  localparam mlen_t MLEN8  = 8'd7;
  localparam mlen_t MLEN16 = 8'd15;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } arb_state_t;

  localparam int unsigned CBUS_ARB_MAX_REQ = 4;

endpackage

// File: rtl/cbus_arb_select.sv
// Combinational winner selection for the cbus arbiter.
// Build option CBUS_ARB_RR_EN: round-robin search starting at rr_ptr;
// otherwise fixed priority with the lowest index winning and rr_ptr ignored.
module cbus_arb_select
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

`ifdef CBUS_ARB_RR_EN
  logic found;
  int   cand;

  // First valid requester found walking forward from rr_ptr, wrapping.
  always_comb begin
    winner    = '0;
    any_valid = |valid;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && valid[cand[IDX_W-1:0]]) begin
        winner = IDX_W'(cand);
        found  = 1'b1;
      end
    end
  end
`else
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  // Lowest-index valid requester wins.
  always_comb begin
    winner    = '0;
    any_valid = |valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[k]) winner = IDX_W'(k);
    end
  end
`endif

endmodule

// File: rtl/cbus_arbiter.sv
// Shares one memory-side cbus port among NUM_REQ requesters. The grant is held
// until the memory returns the last beat, followed by one turnaround cycle.
// All outputs are registered.
// Build option CBUS_ARB_RR_EN selects round-robin instead of fixed priority.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        request_from_src [NUM_REQ],
  output cbus_resp_t       response_to_src  [NUM_REQ],
  output cbus_req_t        request_to_mem,
  input  cbus_resp_t       response_from_mem,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
);

  arb_state_t       state_q, state_d;
  cbus_req_t        req_q, req_d;
  cbus_resp_t       resp_q [NUM_REQ];
  cbus_resp_t       resp_d [NUM_REQ];
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;

  logic [NUM_REQ-1:0] valid_vec;
  logic [IDX_W-1:0]   winner;
  logic               any_valid;
  logic [IDX_W-1:0]   rr_ptr;
  cbus_req_t          sel_req;

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  // Gather valids and mux out the winner's request.
  always_comb begin
    valid_vec = '0;
    sel_req   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_vec[i] = request_from_src[i].valid;
      if (IDX_W'(i) == winner) sel_req = request_from_src[i];
    end
  end

  cbus_arb_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_select (
    .valid     (valid_vec),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Next-state, latched request and per-requester response forwarding.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    grant_d = grant_q;
    for (int i = 0; i < NUM_REQ; i++) resp_d[i] = '0;
`ifdef CBUS_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          req_d   = sel_req;
          grant_d = winner;
          state_d = S_BUSY;
`ifdef CBUS_ARB_RR_EN
          if (int'(winner) == NUM_REQ - 1) rr_ptr_d = '0;
          else                             rr_ptr_d = winner + 1'b1;
`endif
        end
      end
      S_BUSY: begin
        // Memory ready outside S_BUSY is dropped; here every beat is forwarded.
        if (response_from_mem.ready) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == grant_q) resp_d[i] = response_from_mem;
          end
          if (response_from_mem.last) begin
            req_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Gives the winner a cycle to drop valid before re-arbitration.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transaction at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) resp_q[i] <= '0;
`ifdef CBUS_ARB_RR_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NUM_REQ; i++) resp_q[i] <= resp_d[i];
`ifdef CBUS_ARB_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign request_to_mem  = req_q;
  assign response_to_src = resp_q;
  assign grant_idx       = grant_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter: requesters and a memory model issue
// traffic, a transaction-level model predicts grant order and responses, and
// negedge monitors compare what the DUT presents.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int IDXW = $clog2(NREQ);

  logic            clk;
  logic            reset;
  cbus_req_t       request_from_src [NREQ];
  cbus_resp_t      response_to_src  [NREQ];
  cbus_req_t       request_to_mem;
  cbus_resp_t      response_from_mem;
  logic [IDXW-1:0] grant_idx;
  logic            busy;

  cbus_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk               (clk),
    .reset             (reset),
    .request_from_src  (request_from_src),
    .response_to_src   (response_to_src),
    .request_to_mem    (request_to_mem),
    .response_from_mem (response_from_mem),
    .grant_idx         (grant_idx),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int        idx;
    cbus_req_t req;
  } exp_req_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          cyc;
  } exp_resp_t;

  exp_req_t    exp_req_q[$];
  exp_resp_t   exp_resp_q[$];
  cbus_req_t   txn [NREQ][8];
  logic [63:0] mem_data_q[$];

  int        rr_model        = 0;
  bit        mon_en          = 1'b0;
  bit        mem_en          = 1'b0;
  int        mem_force_delay = -1;
  bit        first_pending   = 1'b0;
  int        pres_cyc        = 0;
  int        last_done_cyc   = 0;
  int        cur_idx         = 0;
  cbus_req_t cur_req         = '0;
  logic      prev_valid      = 1'b0;
  exp_req_t  er;
  exp_resp_t ep;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Request monitor: each new grant must match the next predicted transaction.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (request_to_mem.valid && !prev_valid) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got request %h expected none", request_to_mem);
        end else begin
          er = exp_req_q.pop_front();
          cur_req = er.req;
          cur_idx = er.idx;
          check("grant_idx", grant_idx, er.idx);
          check("grant_busy", busy, 1);
          if (first_pending) check("accept_latency", cyc, pres_cyc + 1);
          else               check("turnaround", cyc, last_done_cyc + 2);
          first_pending = 1'b0;
        end
      end
      if (request_to_mem.valid) check("req_hold", request_to_mem, cur_req);
      else                      check("req_idle_zero", request_to_mem, 0);
    end
    prev_valid = request_to_mem.valid;
  end

  // Response monitor: beats go only to the granted port, one cycle after memory.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (response_to_src[i].ready) begin
          if (exp_resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: port %0d got %h expected none", i,
                     response_to_src[i]);
          end else begin
            ep = exp_resp_q.pop_front();
            check("resp_port", i, cur_idx);
            check("resp_data", response_to_src[i].data, ep.data);
            check("resp_last", response_to_src[i].last, ep.last);
            check("resp_cycle", cyc, ep.cyc);
            if (ep.last) last_done_cyc = cyc;
          end
        end else begin
          check("resp_idle_zero", response_to_src[i], 0);
        end
      end
    end
  end

  // Memory model: random latency, 1/2/4 beats, stray ready pulses when idle.
  initial begin
    int          active;
    int          beats;
    int          dly;
    logic [63:0] d;
    active = 0;
    beats  = 0;
    dly    = 0;
    response_from_mem = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_en) begin
        active = 0;
        continue;
      end
      response_from_mem = '0;
      if (active == 0 && request_to_mem.valid) begin
        active = 1;
        beats  = int'(request_to_mem.len) + 1;
        dly    = (mem_force_delay >= 0) ? mem_force_delay : int'($urandom_range(0, 2));
      end
      if (active != 0) begin
        if (dly > 0) begin
          dly--;
        end else begin
          d = (mem_data_q.size() > 0) ? mem_data_q.pop_front() : {$urandom, $urandom};
          response_from_mem = '{ready: 1'b1, last: (beats == 1), data: d};
          exp_resp_q.push_back('{data: d, last: (beats == 1), cyc: cyc + 1});
          beats--;
          if (beats == 0) active = 0;
          else            dly = $urandom_range(0, 1);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        response_from_mem = '{ready: 1'b1, last: 1'($urandom_range(0, 1)),
                              data: {$urandom, $urandom}};
      end
    end
  end

  task automatic gen_txns(input int c0, input int c1);
    int c[NREQ];
    c[0] = c0;
    c[1] = c1;
    for (int p = 0; p < NREQ; p++) begin
      for (int k = 0; k < c[p]; k++) begin
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = 1'($urandom_range(0, 1));
        r.size     = MSIZE8;
        r.addr     = {32'h0, 32'h8000_0000 | ($urandom & 32'h0FFF_FFF8)};
        r.strobe   = r.is_write ? 8'($urandom) : 8'h00;
        r.data     = {$urandom, $urandom};
        case ($urandom_range(0, 2))
          0:       r.len = MLEN1;
          1:       r.len = MLEN2;
          default: r.len = MLEN4;
        endcase
        r.burst   = (r.len == MLEN1) ? AXI_BURST_FIXED : AXI_BURST_INCR;
        txn[p][k] = r;
      end
    end
  endtask

  // Requester: presents its transactions back to back, corrupting the data
  // field once granted (the arbiter must hold its latched copy).
  task automatic port_proc(input int p, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      request_from_src[p] = txn[p][k];
      t = 0;
      forever begin
        @(posedge clk);
        #1;
        t++;
        if (response_to_src[p].ready && response_to_src[p].last) break;
        if (request_to_mem.valid && grant_idx == IDXW'(p))
          request_from_src[p].data = ~txn[p][k].data;
        if (t > 500) begin
          checks++;
          errors++;
          $display("FAIL port%0d_timeout: got no ready&last in %0d cycles expected completion",
                   p, t);
          break;
        end
      end
    end
    request_from_src[p] = '0;
  endtask

  // Model: every requester with work left is valid at each arbitration.
  task automatic run_round(input int c0, input int c1);
    int c[NREQ];
    int rem[NREQ];
    int w;
    c[0] = c0;
    c[1] = c1;
    rem  = c;
    while (rem[0] + rem[1] > 0) begin
      w = -1;
`ifdef CBUS_ARB_RR_EN
      for (int k = 0; k < NREQ; k++) begin
        int q;
        q = (rr_model + k) % NREQ;
        if (w < 0 && rem[q] > 0) w = q;
      end
      rr_model = (w + 1) % NREQ;
`else
      for (int k = NREQ - 1; k >= 0; k--) if (rem[k] > 0) w = k;
`endif
      exp_req_q.push_back('{idx: w, req: txn[w][c[w] - rem[w]]});
      rem[w]--;
    end
    @(posedge clk);
    #1;
    pres_cyc      = cyc;
    first_pending = 1'b1;
    fork
      port_proc(0, c0);
      port_proc(1, c1);
    join
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_req_q.size() + exp_resp_q.size(), 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, request_to_mem, 0);
    check({tag, "_resp0"}, response_to_src[0], 0);
    check({tag, "_resp1"}, response_to_src[1], 0);
    check({tag, "_grant"}, grant_idx, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int c0;
    int c1;
    reset = 1'b1;
    for (int p = 0; p < NREQ; p++) request_from_src[p] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset  = 1'b0;
    mon_en = 1'b1;
    mem_en = 1'b1;

    // Single read on port 1, memory answers two cycles after acceptance.
    gen_txns(0, 1);
    txn[1][0].is_write = 1'b0;
    txn[1][0].addr     = 64'h0000_0000_8000_0010;
    txn[1][0].strobe   = 8'h00;
    txn[1][0].len      = MLEN1;
    txn[1][0].burst    = AXI_BURST_FIXED;
    mem_force_delay    = 2;
    mem_data_q.push_back(64'h0000_0000_DEAD_BEEF);
    run_round(0, 1);
    mem_force_delay = -1;

    // Write pass-through on port 0.
    gen_txns(1, 0);
    txn[0][0].is_write = 1'b1;
    txn[0][0].strobe   = 8'h0F;
    txn[0][0].data     = 64'h0000_0000_1122_3344;
    txn[0][0].len      = MLEN1;
    txn[0][0].burst    = AXI_BURST_FIXED;
    run_round(1, 0);

    // Simultaneous pairs.
    gen_txns(1, 1);
    run_round(1, 1);
    gen_txns(1, 1);
    run_round(1, 1);

    // Four-beat burst.
    gen_txns(0, 1);
    txn[1][0].len   = MLEN4;
    txn[1][0].burst = AXI_BURST_INCR;
    run_round(0, 1);

    // Both ports busy for ten transactions.
    gen_txns(5, 5);
    run_round(5, 5);

    // Reset in the middle of a pending transaction.
    mon_en = 1'b0;
    mem_en = 1'b0;
    response_from_mem = '0;
    @(posedge clk);
    #1;
    gen_txns(0, 1);
    request_from_src[1] = txn[1][0];
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    check("pre_reset_grant", grant_idx, 1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    request_from_src[1] = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    response_from_mem = '{ready: 1'b1, last: 1'b1, data: 64'h55};
    @(posedge clk);
    #1;
    response_from_mem = '0;
    @(posedge clk);
    #1;
    check_all_zero("late_ready");
    rr_model = 0;
    exp_req_q.delete();
    exp_resp_q.delete();
    mem_en = 1'b1;
    mon_en = 1'b1;

    // Random traffic.
    for (int r = 0; r < 15; r++) begin
      c0 = $urandom_range(0, 3);
      c1 = $urandom_range(0, 3);
      if (c0 + c1 == 0) c0 = 1;
      gen_txns(c0, c1);
      run_round(c0, c1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
